// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC unit: forms redirect targets, owns the PC, drives fetch-valid/flush/halt.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter int           N             = 32,
    parameter logic [N-1:0] RESET_PC      = '0,
    parameter logic [N-1:0] TRAP_VEC      = N'(32'h0000_0100),
    parameter int           BUBBLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         halt_i,
    input  logic         br_valid_i,
    input  logic         br_taken_i,
    input  logic         br_is_jalr_i,
    input  logic [N-1:0] br_base_i,
    input  logic [N-1:0] br_imm_i,
    output logic [N-1:0] pc_o,
    output logic         fetch_valid_o,
    output logic         flush_o,
    output logic         exc_misalign_o,
    output logic [N-1:0] exc_tval_o,
    output logic         halted_o
);
    typedef enum logic [1:0] {S_START, S_RUN, S_BUBBLE, S_HALT} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d, tval_q, tval_d, tgt;
    logic [1:0]   cnt_q, cnt_d;
    logic         vld_q, vld_d, flush_q, flush_d, exc_q, exc_d, halted_q, halted_d;
    logic         redirect, misalign;

    always_comb begin
        tgt = br_base_i + br_imm_i;
        if (br_is_jalr_i) tgt[0] = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misalign = tgt[1];
`else
        tgt[1:0] = 2'b00;
        misalign = 1'b0;
`endif
    end

    assign redirect = (state_q == S_RUN || state_q == S_BUBBLE) && br_valid_i && br_taken_i;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        flush_d  = 1'b0;
        exc_d    = 1'b0;
        tval_d   = tval_q;
        halted_d = halted_q;
        case (state_q)
            S_START: begin
                state_d = S_RUN;
                vld_d   = 1'b1;
            end
            S_RUN, S_BUBBLE: begin
                if (halt_i) begin
                    state_d  = S_HALT;
                    vld_d    = 1'b0;
                    halted_d = 1'b1;
                end else if (redirect) begin
                    flush_d = 1'b1;
                    if (misalign) begin
                        pc_d   = TRAP_VEC;
                        exc_d  = 1'b1;
                        tval_d = tgt;
                    end else begin
                        pc_d = tgt;
                    end
                    if (BUBBLE_CYCLES > 0) begin
                        state_d = S_BUBBLE;
                        vld_d   = 1'b0;
                        cnt_d   = 2'(BUBBLE_CYCLES);
                    end else begin
                        state_d = S_RUN;
                        vld_d   = 1'b1;
                    end
                end else if (state_q == S_RUN) begin
                    if (!stall_i) pc_d = pc_q + N'(4);
                end else begin
                    // bubble drains even while stalled; PC holds through the exit edge
                    if (cnt_q <= 2'd1) begin
                        state_d = S_RUN;
                        vld_d   = 1'b1;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_START;
            pc_q     <= RESET_PC;
            cnt_q    <= 2'd0;
            vld_q    <= 1'b0;
            flush_q  <= 1'b0;
            exc_q    <= 1'b0;
            tval_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            flush_q  <= flush_d;
            exc_q    <= exc_d;
            tval_q   <= tval_d;
            halted_q <= halted_d;
        end
    end

    assign pc_o           = pc_q;
    assign fetch_valid_o  = vld_q;
    assign flush_o        = flush_q;
    assign exc_misalign_o = exc_q;
    assign exc_tval_o     = tval_q;
    assign halted_o       = halted_q;

endmodule
